input_skew_feeder: RTL and testbench

INPUT_SKEW_FEEDER -- requirements
Module: input_skew_feeder

---
 rtl/input_skew_feeder_pkg.sv | 16 +
 rtl/input_skew_feeder_tile_buffer.sv | 31 +++
 rtl/input_skew_feeder.sv | 137 +++++++++++++
 tb/tb_input_skew_feeder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_skew_feeder_pkg.sv
// Shared word-width define and common types/helpers for the systolic array, PE and input feeder.
`ifndef DATA_W
`define DATA_W 8
`endif

package input_skew_feeder_pkg;

   localparam int unsigned DATA_W             = `DATA_W;
   localparam int unsigned DEFAULT_ARRAY_SIZE = 4;

   // True when row `row` holds a real tile element in skewed column `col`.
   function automatic bit skew_hit(input int col, input int row, input int n);
      return ((col - row) >= 0) && ((col - row) < n);
   endfunction

endpackage

// File: rtl/input_skew_feeder_tile_buffer.sv
// Activation tile storage: one synchronous write port, ARRAY_SIZE combinational read ports.
module tile_buffer
   import input_skew_feeder_pkg::*;
#(
   parameter int unsigned ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
   localparam int unsigned DEPTH     = ARRAY_SIZE * ARRAY_SIZE,
   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                                 clk,
   input  logic                                 we,
   input  logic [AW-1:0]                        waddr,
   input  logic [DATA_W-1:0]                    wdata,
   input  logic [ARRAY_SIZE-1:0][AW-1:0]        raddr,
   output logic [ARRAY_SIZE-1:0][DATA_W-1:0]    rdata_c
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
         rdata_c[i] = mem[raddr[i]];
      end
   end

endmodule

// File: rtl/input_skew_feeder.sv
// Loads one ARRAY_SIZE x ARRAY_SIZE activation tile, then streams it row-skewed into a systolic array.
module input_skew_feeder
   import input_skew_feeder_pkg::*;
#(
   parameter int unsigned ARRAY_SIZE = DEFAULT_ARRAY_SIZE
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_valid,
   input  logic [`DATA_W-1:0]               wr_data,
   output logic                             wr_ready,
   input  logic                             start,
   output logic [ARRAY_SIZE*`DATA_W-1:0]    x_out,
   output logic [ARRAY_SIZE-1:0]            x_valid,
   output logic                             busy,
   output logic                             done
);

   localparam int unsigned DEPTH  = ARRAY_SIZE * ARRAY_SIZE;
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LAST_T = 2 * ARRAY_SIZE - 2;
   localparam int unsigned TW     = $clog2(2 * ARRAY_SIZE);

   localparam logic [1:0] S_LOAD   = 2'd0;
   localparam logic [1:0] S_FULL   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]                              state;
   logic [AW-1:0]                           wr_cnt;
   logic [TW-1:0]                           t;

   logic                                    wr_fire_c;
   logic                                    start_accept_c;
   logic [TW-1:0]                           col_c;
   logic [ARRAY_SIZE-1:0][AW-1:0]           raddr_c;
   logic [ARRAY_SIZE-1:0][DATA_W-1:0]       rdata_c;
   logic [ARRAY_SIZE*DATA_W-1:0]            col_data_c;
   logic [ARRAY_SIZE-1:0]                   col_valid_c;

   assign wr_fire_c      = (state == S_LOAD) && wr_valid && wr_ready;
   assign start_accept_c = (state == S_FULL) && start;

   // Outputs are registered, so the column loaded at each edge is the one for the following cycle.
   assign col_c = start_accept_c ? '0 : TW'(t + 1'b1);

   tile_buffer #(
      .ARRAY_SIZE (ARRAY_SIZE)
   ) u_tile_buffer (
      .clk     (clk),
      .we      (wr_fire_c),
      .waddr   (wr_cnt),
      .wdata   (wr_data),
      .raddr   (raddr_c),
      .rdata_c (rdata_c)
   );

   // Skewed column: row i carries A[i][col-i] while that index lies inside the tile.
   always_comb begin
      raddr_c     = '0;
      col_data_c  = '0;
      col_valid_c = '0;
      for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
         if (skew_hit(int'(col_c), i, int'(ARRAY_SIZE))) begin
            raddr_c[i]                   = AW'(i * int'(ARRAY_SIZE) + int'(col_c) - i);
            col_data_c[i*DATA_W +: DATA_W] = rdata_c[i];
            col_valid_c[i]               = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_LOAD;
         wr_cnt   <= '0;
         t        <= '0;
         x_out    <= '0;
         x_valid  <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         wr_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            S_LOAD: begin
               if (wr_fire_c) begin
                  if (wr_cnt == AW'(DEPTH - 1)) begin
                     wr_cnt   <= '0;
                     wr_ready <= 1'b0;
                     state    <= S_FULL;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            S_FULL: begin
               if (start_accept_c) begin
                  state   <= S_STREAM;
                  t       <= '0;
                  busy    <= 1'b1;
                  x_out   <= col_data_c;
                  x_valid <= col_valid_c;
               end
            end
            S_STREAM: begin
               if (t == TW'(LAST_T)) begin
                  state   <= S_DONE;
                  t       <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  x_out   <= '0;
                  x_valid <= '0;
               end else begin
                  t       <= t + 1'b1;
                  x_out   <= col_data_c;
                  x_valid <= col_valid_c;
               end
            end
            S_DONE: begin
               state    <= S_LOAD;
               wr_cnt   <= '0;
               wr_ready <= 1'b1;
            end
            default: begin
               state    <= S_LOAD;
               wr_cnt   <= '0;
               t        <= '0;
               busy     <= 1'b0;
               x_out    <= '0;
               x_valid  <= '0;
               wr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed self-checking bench for input_skew_feeder (ARRAY_SIZE = 4).
module tb_input_skew_feeder;
   import input_skew_feeder_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned W     = DATA_W;
   localparam int unsigned DEPTH = N * N;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_valid;
   logic [W-1:0]     wr_data;
   logic             wr_ready;
   logic             start;
   logic [N*W-1:0]   x_out;
   logic [N-1:0]     x_valid;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] tile_m [DEPTH];

   // Hand-computed skew of the tile 1..16 (row 0 in the low byte).
   logic [31:0] gold_x [7] = '{32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704,
                               32'h0E0B0800, 32'h0F0C0000, 32'h10000000};
   logic [3:0]  gold_v [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

   input_skew_feeder #(.ARRAY_SIZE(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .start    (start),
      .x_out    (x_out),
      .x_valid  (x_valid),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [N*W-1:0] exp_x(input int c);
      logic [N*W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(N); i++) begin
         if ((c - i) >= 0 && (c - i) < int'(N)) r[i*W +: W] = tile_m[i*int'(N) + c - i];
      end
      return r;
   endfunction

   function automatic logic [N-1:0] exp_v(input int c);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < int'(N); i++) begin
         if ((c - i) >= 0 && (c - i) < int'(N)) r[i] = 1'b1;
      end
      return r;
   endfunction

   task automatic load_words(input int first, input int last, input logic [W-1:0] base);
      for (int j = first; j <= last; j++) begin
         wr_valid   = 1'b1;
         wr_data    = base + W'(j);
         tile_m[j]  = wr_data;
         tick();
      end
      wr_valid = 1'b0;
   endtask

   // Accepts start, checks every skewed column against the model, and stops in the DONE cycle.
   task automatic run_stream(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= int'(2*N - 2); c++) begin
         check($sformatf("%s_x%0d", tag, c), 64'(x_out), 64'(exp_x(c)));
         check($sformatf("%s_v%0d", tag, c), 64'(x_valid), 64'(exp_v(c)));
         check($sformatf("%s_busy%0d", tag, c), 64'(busy), 64'd1);
         tick();
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_done_busy"}, 64'(busy), 64'd0);
      check({tag, "_done_x"}, 64'(x_out), 64'd0);
      check({tag, "_done_v"}, 64'(x_valid), 64'd0);
      check({tag, "_done_ready"}, 64'(wr_ready), 64'd0);
   endtask

   task automatic after_done(input string tag);
      tick();
      check({tag, "_pulse_end"}, 64'(done), 64'd0);
      check({tag, "_ready_back"}, 64'(wr_ready), 64'd1);
   endtask

   initial begin
      int   accepted;
      int   cyc;
      logic hs;

      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", 64'(wr_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_x", 64'(x_out), 64'd0);
      check("rst_v", 64'(x_valid), 64'd0);

      // Basic tile 1..16 against the hand-computed table
      load_words(0, 15, W'(1));
      check("t1_full_ready", 64'(wr_ready), 64'd0);
      check("t1_full_busy", 64'(busy), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 7; c++) begin
         check($sformatf("t1_x%0d", c), 64'(x_out), 64'(gold_x[c]));
         check($sformatf("t1_v%0d", c), 64'(x_valid), 64'(gold_v[c]));
         tick();
      end
      check("t1_done", 64'(done), 64'd1);
      check("t1_done_v", 64'(x_valid), 64'd0);
      after_done("t1");

      // Start with a partial tile is dropped
      load_words(0, 9, W'('h30));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2_partial_busy", 64'(busy), 64'd0);
      check("t2_partial_ready", 64'(wr_ready), 64'd1);
      check("t2_partial_v", 64'(x_valid), 64'd0);
      tick();
      check("t2_no_pending", 64'(busy), 64'd0);
      load_words(10, 15, W'('h30));
      check("t2_full_ready", 64'(wr_ready), 64'd0);
      tick();
      check("t2_wait_busy", 64'(busy), 64'd0);
      run_stream("t2");
      after_done("t2");

      // Writes offered while FULL are ignored
      load_words(0, 15, W'('h40));
      wr_valid = 1'b1;
      wr_data  = W'('hAA);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t3_ready%0d", k), 64'(wr_ready), 64'd0);
         check($sformatf("t3_busy%0d", k), 64'(busy), 64'd0);
         tick();
      end
      wr_valid = 1'b0;
      run_stream("t3");
      after_done("t3");

      // Reset mid-stream, with start and wr_valid also high
      load_words(0, 15, W'('h50));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("t4_pre_x", 64'(x_out), 64'(exp_x(3)));
      rst = 1'b1; start = 1'b1; wr_valid = 1'b1; wr_data = W'('hAA);
      tick();
      rst = 1'b0; start = 1'b0; wr_valid = 1'b0;
      check("t4_rst_v", 64'(x_valid), 64'd0);
      check("t4_rst_x", 64'(x_out), 64'd0);
      check("t4_rst_busy", 64'(busy), 64'd0);
      check("t4_rst_ready", 64'(wr_ready), 64'd1);
      check("t4_rst_done", 64'(done), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_stale_busy", 64'(busy), 64'd0);
      load_words(0, 15, W'('h10));
      run_stream("t4");
      after_done("t4");

      // Random wr_valid toggling: exactly 16 handshakes
      accepted = 0;
      cyc      = 0;
      while (accepted < int'(DEPTH) && cyc < 200) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data  = W'($urandom_range(0, 255));
         hs       = wr_valid && wr_ready;
         if (hs) tile_m[accepted] = wr_data;
         tick();
         if (hs) accepted++;
         cyc++;
      end
      wr_valid = 1'b1;
      wr_data  = W'('hAA);
      tick();
      wr_valid = 1'b0;
      check("t5_accepted", 64'(accepted), 64'(DEPTH));
      check("t5_ready", 64'(wr_ready), 64'd0);
      run_stream("t5");

      // Word offered in DONE is refused; next tile loads right after
      wr_valid = 1'b1;
      wr_data  = W'('hEE);
      tick();
      wr_valid = 1'b0;
      check("t6_ready", 64'(wr_ready), 64'd1);
      check("t6_done_low", 64'(done), 64'd0);
      load_words(0, 15, W'('h60));
      check("t6_full_ready", 64'(wr_ready), 64'd0);
      run_stream("t6");
      after_done("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
